// File: rtl/demux_1t8_nb_hs_if.sv
// Handshake bundle for the 1-to-8 distributor: one upstream port, eight downstream channels.
// The slave modport is the distributor itself; master is the producer/consumer side.
interface demux_1t8_nb_hs_if #(
    parameter int n = 8
) ();
    logic           in_vld;
    logic           in_rdy;
    logic [2:0]     sel;
    logic           bcast;
    logic [n-1:0]   d_in;
    logic [7:0]     out_vld;
    logic [7:0]     out_rdy;
    logic [8*n-1:0] d_out;
    logic           busy;

    modport master (
        output in_vld,
        output sel,
        output bcast,
        output d_in,
        output out_rdy,
        input  in_rdy,
        input  out_vld,
        input  d_out,
        input  busy
    );

    modport slave (
        input  in_vld,
        input  sel,
        input  bcast,
        input  d_in,
        input  out_rdy,
        output in_rdy,
        output out_vld,
        output d_out,
        output busy
    );
endinterface

// File: rtl/demux_1t8_nb_hs.sv
// Registered 1-to-8 distributor: each channel owns a one-entry holding register, so a
// stalled consumer only blocks words addressed to it (or broadcasts).
module demux_1t8_nb_hs #(
    parameter int n = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_1t8_nb_hs_if.slave   bus
);

    logic [7:0]   vld_reg;
    logic [n-1:0] data_reg [8];
    logic [7:0]   free;
    logic [7:0]   target;
    logic         in_rdy_next;
    logic         accept;

    // A channel can take a new word if it is empty or its current word leaves this cycle.
    assign free = ~vld_reg | bus.out_rdy;

    always_comb begin
        target = 8'h00;
        if (bus.bcast) begin
            target = 8'hFF;
        end else begin
            target[bus.sel] = 1'b1;
        end
    end

    // Ready depends only on channel state and routing, never on in_vld.
    always_comb begin
        in_rdy_next = 1'b0;
        if (bus.bcast) begin
            in_rdy_next = &free;
        end else begin
            in_rdy_next = free[bus.sel];
        end
    end

    assign accept     = bus.in_vld & in_rdy_next;
    assign bus.in_rdy = in_rdy_next;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            // Load wins over drain, which keeps one word per cycle flowing through a channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_reg[gi]  <= 1'b0;
                    data_reg[gi] <= '0;
                end else if (accept && target[gi]) begin
                    vld_reg[gi]  <= 1'b1;
                    data_reg[gi] <= bus.d_in;
                end else if (bus.out_rdy[gi]) begin
                    vld_reg[gi]  <= 1'b0;
                end
            end

            assign bus.d_out[gi*n +: n] = data_reg[gi];
        end
    endgenerate

    assign bus.out_vld = vld_reg;
    assign bus.busy    = |vld_reg;

endmodule

// File: doc/demux_1t8_nb_hs.md
Name: demux_1t8_nb_hs

Overview:
- Registered 1-to-8 distributor with valid/ready handshakes, n-bit data path.
- Accepts one word per cycle from a single upstream source and routes it to one of eight downstream channels selected by SEL, or to all eight when BCAST is asserted.
- Each channel has a one-entry holding register, so a stalled consumer blocks only writes addressed to its own channel.
- Sits between a single producer (e.g. a datapath result bus) and multiple independent consumers (peripherals, register banks).

Parameters:
- n, 8, data width in bits of D_IN and of each output channel.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VLD  input  1  upstream word valid.
- IN_RDY  output  1  block can accept the word this cycle.
- SEL  input  3  destination channel index 0..7; ignored when BCAST=1.
- BCAST  input  1  broadcast: word goes to all eight channels.
- D_IN  input  n  upstream data.
- OUT_VLD  output  8  bit k = channel k holds a valid word.
- OUT_RDY  input  8  bit k = consumer k takes the word this cycle.
- D_OUT  output  8*n  channel k data on bits [k*n+n-1 : k*n].
- BUSY  output  1  OR of OUT_VLD.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All OUT_VLD=0, all channel data registers=0, BUSY=0.
  - Any word held in a channel is discarded.
  - Release takes effect on the first CLK edge with RST_N=1.
- Channel k state, one bit (EMPTY/FULL = OUT_VLD[k]):
  - drain_k = OUT_VLD[k] & OUT_RDY[k].
  - free_k = ~OUT_VLD[k] | OUT_RDY[k] (empty, or draining this cycle).
- Combinational readiness (pass-through):
  - BCAST=0: IN_RDY = free_SEL.
  - BCAST=1: IN_RDY = AND of free_k over k=0..7.
  - IN_RDY does not depend on IN_VLD, so there is no combinational loop.
- Transfer: accept = IN_VLD & IN_RDY. On the clock edge with accept:
  - every target channel loads D_IN into its data register and sets OUT_VLD[k]=1;
  - the targets are SEL, or all channels when BCAST=1.
- A non-target channel with drain_k clears OUT_VLD[k]. Its data register holds its last value; D_OUT content is don't-care while OUT_VLD[k]=0.
- Simultaneous drain and load on the same channel is legal: the register loads the new word and OUT_VLD stays 1. This gives full throughput, one word per cycle per channel.
- Latency: D_IN appears on D_OUT slice k with OUT_VLD[k]=1 exactly one cycle after accept.
- Ordering: words to the same channel are delivered in acceptance order.
- No reordering across channels is possible because each channel holds one entry.
- When IN_VLD=1 and IN_RDY=0:
  - nothing is written;
  - upstream must hold IN_VLD, SEL, BCAST and D_IN stable until accept;
  - the block does not check this.
- OUT_VLD[k], once set, stays 1 until OUT_RDY[k] is sampled high. Data is stable while it is held.
- OUT_RDY[k] while OUT_VLD[k]=0 has no effect.
- BUSY=1 in any cycle where some OUT_VLD bit is 1.
- Width rules:
  - D_OUT is a concatenation, channel 0 in the LSBs.
  - No arithmetic is performed; SEL covers all 8 channels, so there is no out-of-range case.

Test Plan:
1. Reset: RST_N=0 asserted mid-cycle while OUT_VLD=8'h24 -> OUT_VLD=8'h00, D_OUT=0 immediately, without waiting for a CLK edge; BUSY=0.
2. Single route: n=8, OUT_RDY=8'h00, IN_VLD=1, SEL=5, D_IN=8'hA7 -> IN_RDY=1; next cycle OUT_VLD=8'h20, D_OUT[47:40]=8'hA7, BUSY=1.
3. Back-pressure: channel 5 full with OUT_RDY[5]=0, then IN_VLD=1, SEL=5, D_IN=8'h3C:
   - IN_RDY=0 and channel 5 keeps 8'hA7;
   - raise OUT_RDY[5] -> IN_RDY=1 in the same cycle; next cycle channel 5=8'h3C, OUT_VLD[5]=1.
4. Streaming: OUT_RDY=8'hFF, SEL=2, D_IN=1,2,3,4 on consecutive cycles -> IN_RDY held 1; channel 2 outputs 1,2,3,4 on consecutive cycles, each one cycle later.
5. Broadcast:
   - OUT_VLD=8'h01 with OUT_RDY=8'h00, BCAST=1, D_IN=8'h55 -> IN_RDY=0;
   - set OUT_RDY[0]=1 -> accept; next cycle OUT_VLD=8'hFF, every slice=8'h55.
6. Independence: channel 1 full and stalled, IN_VLD=1, SEL=6 -> accepted; channel 6 loads, channel 1 unchanged; then OUT_RDY=8'h42 -> OUT_VLD=8'h00 next cycle.
